isched_stream: RTL and testbench

Parametrised input scheduler that walks a range of memory rows, reads each row of `CHUNKS` × `CHUNK_W` bits, and streams it MSB-chunk-first onto a valid/ready output channel toward the compute datapath. It generalises the fixed 4 × 48-bit scheduler in three ways:
- programmable start/end addresses with wrap-around;
- proper back-pressure;
- a synchronous abort.

It sits between the input SRAM and the MAC array feed.

---
 rtl/isched_stream.sv | 173 +++++++++++++++++
 tb/tb_isched_stream.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/isched_stream.sv
// isched_stream: walks memory rows start_addr..end_addr (wrapping at the top of
// the address space). Each row is read from a synchronous SRAM and streamed
// MSB-chunk-first on a valid/ready channel.
// Optional feature macro: ISCHED_ZERO_SKIP_EN. When it is defined, all-zero
// chunks are never presented. When it is undefined, every chunk is streamed.

// Per-chunk output lane: drives its chunk onto the shared OR bus only while the
// scheduler is emitting and the chunk index selects this lane.
module isched_stream_lane #(
   parameter int CHUNK_W = 48,
   parameter int IDX_W   = 2,
   parameter int LANE    = 0
) (
   input  logic [CHUNK_W-1:0] chunk,
   input  logic [IDX_W-1:0]   idx,
   input  logic               emit,
   output logic [CHUNK_W-1:0] selData
);
   logic sel;

   // one-hot select keeps out_data a plain AND-OR tree with no wide mux
   always_comb begin
      sel     = emit && (idx == IDX_W'(LANE));
      selData = sel ? chunk : '0;
   end
endmodule

module isched_stream #(
   parameter int CHUNK_W = 48,
   parameter int CHUNKS  = 4,
   parameter int ADDR_W  = 8
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      abort,
   input  logic [ADDR_W-1:0]         start_addr,
   input  logic [ADDR_W-1:0]         end_addr,
   output logic                      mem_rd,
   output logic [ADDR_W-1:0]         mem_addr,
   input  logic [CHUNK_W*CHUNKS-1:0] mem_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [CHUNK_W-1:0]        out_data,
   output logic                      out_last_chunk,
   output logic                      out_last_row,
   output logic                      busy,
   output logic                      done
);
   localparam int IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

   typedef enum logic [2:0] {IDLE, FETCH, WAIT, EMIT, DONE} state_t;

   state_t                          state, nextState;
   logic [ADDR_W-1:0]               rowPtr, endAddrQ;
   logic [CHUNKS-1:0][CHUNK_W-1:0]  rowBuf, memRow;
   logic [CHUNKS-1:0][CHUNK_W-1:0]  laneData;   // indexed in presentation order
   logic [IDX_W-1:0]                chunkIdx, nextIdx, firstIdx;
   logic                            emitting, xfer, isLast, lastRow, rowEmpty;

   assign memRow   = mem_data;
   assign emitting = (state == EMIT);
   assign xfer     = emitting && out_ready;
   assign lastRow  = (rowPtr == endAddrQ);

   // lane g presents chunk g, i.e. row bits counted down from the MSB end
   for (genvar g = 0; g < CHUNKS; g++) begin : gLane
      isched_stream_lane #(.CHUNK_W(CHUNK_W), .IDX_W(IDX_W), .LANE(g)) uLane (
         .chunk   (rowBuf[CHUNKS-1-g]),
         .idx     (chunkIdx),
         .emit    (emitting),
         .selData (laneData[g])
      );
   end

`ifdef ISCHED_ZERO_SKIP_EN
   logic [CHUNKS-1:0] bufNz, memNz;
   logic              nxtFound, memFound;

   for (genvar g = 0; g < CHUNKS; g++) begin : gNz
      assign bufNz[g] = |rowBuf[CHUNKS-1-g];
      assign memNz[g] = |memRow[CHUNKS-1-g];
   end

   // {found, index} of the lowest set mask bit at or above 'from'
   function automatic logic [IDX_W:0] firstFrom(input logic [CHUNKS-1:0] mask, input int from);
      logic [IDX_W:0] r;
      r = '0;
      for (int j = CHUNKS - 1; j >= 0; j--)
         if (j >= from && mask[j]) r = {1'b1, IDX_W'(j)};
      return r;
   endfunction

   // skip decode: next nonzero chunk of the buffered row, first nonzero chunk of the incoming row
   always_comb begin
      {nxtFound, nextIdx} = firstFrom(bufNz, int'(chunkIdx) + 1);
      {memFound, firstIdx} = firstFrom(memNz, 0);
      isLast   = !nxtFound;
      rowEmpty = !memFound;
   end
`else
   // plain decode: every chunk is presented, last one is index CHUNKS-1
   always_comb begin
      nextIdx  = chunkIdx + 1'b1;
      firstIdx = '0;
      isLast   = (chunkIdx == IDX_W'(CHUNKS - 1));
      rowEmpty = 1'b0;
   end
`endif

   // state register
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   // next-state logic; abort overrides everything but reset
   always_comb begin
      nextState = state;
      if (abort) nextState = IDLE;
      else begin
         case (state)
            IDLE:    if (start) nextState = FETCH;
            FETCH:   nextState = WAIT;
            WAIT:    if (rowEmpty) nextState = lastRow ? DONE : FETCH;
                     else          nextState = EMIT;
            EMIT:    if (xfer && isLast) nextState = lastRow ? DONE : FETCH;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
         endcase
      end
   end

   // row pointer, end address, row buffer and chunk index
   always_ff @(posedge clock) begin
      if (reset) begin
         endAddrQ <= '0;
         rowPtr   <= '0;
         rowBuf   <= '0;
         chunkIdx <= '0;
      end else if (!abort) begin
         case (state)
            IDLE: if (start) begin
               endAddrQ <= end_addr;
               rowPtr   <= start_addr;
            end
            WAIT: begin
               rowBuf   <= memRow;
               chunkIdx <= firstIdx;
               if (rowEmpty && !lastRow) rowPtr <= rowPtr + 1'b1;
            end
            EMIT: if (xfer) begin
               if (!isLast)      chunkIdx <= nextIdx;
               else if (!lastRow) rowPtr  <= rowPtr + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // outputs decoded from registered state only; out_ready never reaches valid/data
   always_comb begin
      mem_rd         = (state == FETCH);
      mem_addr       = rowPtr;
      busy           = (state != IDLE);
      done           = (state == DONE);
      out_valid      = emitting;
      out_last_chunk = emitting && isLast;
      out_last_row   = emitting && lastRow;
      out_data       = '0;
      for (int g = 0; g < CHUNKS; g++) out_data = out_data | laneData[g];
   end
endmodule

// File: tb/tb_isched_stream.sv
// Directed bench for isched_stream with a scoreboard of expected chunks and
// read addresses, filled when each scan is started and drained by a monitor.
module tb_isched_stream;
   localparam int CW = 48, NC = 4, AW = 8, RW = CW * NC;

   logic          clock = 1'b0;
   logic          reset, start, abort, out_ready;
   logic [AW-1:0] start_addr, end_addr, mem_addr;
   logic          mem_rd, out_valid, out_last_chunk, out_last_row, busy, done;
   logic [RW-1:0] memData;
   logic [CW-1:0] out_data;

   isched_stream #(.CHUNK_W(CW), .CHUNKS(NC), .ADDR_W(AW)) dut (
      .clock(clock), .reset(reset), .start(start), .abort(abort),
      .start_addr(start_addr), .end_addr(end_addr),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(memData),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last_chunk(out_last_chunk), .out_last_row(out_last_row),
      .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [CW-1:0] d;
      logic          lc;
      logic          lr;
   } exp_t;

   int            total = 0, bad = 0, cyc = 0, lastXferCyc = 0;
   logic [RW-1:0] mem [0:255];
   exp_t          expQ [$];
   logic [AW-1:0] addrQ [$];
   exp_t          monE;
   logic          prevStall = 1'b0;
   logic [CW-1:0] prevData = '0;

   // synchronous SRAM: data one cycle after the read strobe
   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (reset)       memData <= '0;
      else if (mem_rd) memData <= mem[mem_addr];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [RW-1:0] mkRow(input logic [CW-1:0] c0, c1, c2, c3);
      return {c0, c1, c2, c3};
   endfunction

   task automatic pushRow(input logic [AW-1:0] a, input logic lr);
      logic [RW-1:0] row;
      logic [CW-1:0] c;
      int            lastNz;
      row    = mem[a];
      lastNz = -1;
      for (int i = 0; i < NC; i++) if (row[(NC-i)*CW-1 -: CW] != '0) lastNz = i;
      for (int i = 0; i < NC; i++) begin
         c = row[(NC-i)*CW-1 -: CW];
`ifdef ISCHED_ZERO_SKIP_EN
         if (c != '0) expQ.push_back(exp_t'{d: c, lc: (i == lastNz), lr: lr});
`else
         expQ.push_back(exp_t'{d: c, lc: (i == NC - 1), lr: lr});
`endif
      end
   endtask

   task automatic pushScan(input logic [AW-1:0] s, input logic [AW-1:0] e);
      logic [AW-1:0] a;
      a = s;
      for (int n = 0; n < 256; n++) begin
         addrQ.push_back(a);
         pushRow(a, a == e);
         if (a == e) break;
         a = a + 1'b1;
      end
   endtask

   task automatic doStart(input logic [AW-1:0] s, input logic [AW-1:0] e);
      start_addr = s;
      end_addr   = e;
      start      = 1'b1;
      pushScan(s, e);
      tick();
      start = 1'b0;
   endtask

   task automatic chkResetOuts(input string tag);
      chk(tag, 64'({mem_rd, mem_addr, out_valid, out_data, out_last_chunk,
                    out_last_row, busy, done}), 64'(0));
   endtask

   task automatic waitValid(input int budget);
      for (int i = 0; i < budget && !out_valid; i++) tick();
      chk("valid_seen", 64'(out_valid), 64'(1));
   endtask

   task automatic waitDone(input int budget, input int expLat);
      for (int i = 0; i < budget && !done; i++) tick();
      chk("done_seen", 64'(done), 64'(1));
      chk("done_latency", 64'(cyc - lastXferCyc), 64'(expLat));
      chk("queue_drained", 64'(expQ.size() + addrQ.size()), 64'(0));
      tick();
      chk("done_pulse", 64'(done), 64'(0));
      chk("busy_fall", 64'(busy), 64'(0));
   endtask

   // monitor: read addresses, transfers against the scoreboard, stall stability
   always @(negedge clock) begin
      if (reset) prevStall = 1'b0;
      else begin
         if (mem_rd) begin
            if (addrQ.size() == 0) chk("addr_unexpected", 64'(mem_rd), 64'(0));
            else                   chk("mem_addr", 64'(mem_addr), 64'(addrQ.pop_front()));
         end
         if (prevStall && out_valid)
            chk("hold_stable", 64'({out_data, out_last_chunk, out_last_row}), 64'({prevData, monE.lc, monE.lr}));
         if (out_valid && out_ready) begin
            if (expQ.size() == 0) chk("chunk_unexpected", 64'(out_valid), 64'(0));
            else begin
               monE = expQ.pop_front();
               chk("chunk_data", 64'(out_data), 64'(monE.d));
               chk("chunk_last", 64'(out_last_chunk), 64'(monE.lc));
               chk("row_last", 64'(out_last_row), 64'(monE.lr));
            end
            lastXferCyc = cyc;
         end else if (out_valid && expQ.size() != 0) begin
            monE = expQ[0];
         end
         prevStall = out_valid && !out_ready;
         prevData  = out_data;
      end
   end

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
      start_addr = '0; end_addr = '0;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      tick(); tick();
      chkResetOuts("reset_state");
      reset = 1'b0;
      tick();

      // basic two-row scan with start latency checks
      mem[0] = mkRow(48'h1, 48'h2, 48'h3, 48'h4);
      mem[1] = mkRow(48'h5, 48'h6, 48'h7, 48'h8);
      doStart(8'h00, 8'h01);
      chk("lat_mem_rd", 64'({mem_rd, mem_addr}), 64'({1'b1, 8'h00}));
      tick();
      chk("lat_wait_invalid", 64'(out_valid), 64'(0));
      tick();
      chk("lat_first_valid", 64'({out_valid, out_data}), 64'({1'b1, 48'h1}));
      waitDone(40, 1);

      // back-pressure on the second chunk for five cycles
      doStart(8'h00, 8'h01);
      waitValid(10);
      tick();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_hold_chunk2", 64'({out_valid, out_data}), 64'({1'b1, 48'h2}));
      end
      out_ready = 1'b1;
      waitDone(40, 1);

      // wrap-around FE..01, with a start pulse mid-scan that must be ignored
      for (int a = 0; a < 4; a++) begin
         logic [AW-1:0] wa;
         wa = 8'hFE + AW'(a);
         mem[wa] = mkRow(48'(wa) * 16 + 1, 48'(wa) * 16 + 2, 48'(wa) * 16 + 3, 48'(wa) * 16 + 4);
      end
      doStart(8'hFE, 8'h01);
      tick(); tick(); tick();
      start_addr = 8'h40; end_addr = 8'h40; start = 1'b1;
      tick();
      start = 1'b0;
      waitDone(80, 1);

      // abort during the third chunk of row 0, then rescan a single row
      mem[0] = mkRow(48'h1, 48'h2, 48'h3, 48'h4);
      mem[1] = mkRow(48'h5, 48'h6, 48'h7, 48'h8);
      doStart(8'h00, 8'h01);
      waitValid(10);
      tick(); tick();
      chk("abort_at_chunk3", 64'(out_data), 64'(48'h3));
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_outs", 64'({out_valid, busy, mem_rd, done}), 64'(0));
      expQ.delete();
      addrQ.delete();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("abort_no_done", 64'({done, busy}), 64'(0));
      end
      mem[5] = mkRow(48'h9, 48'hA, 48'hB, 48'hC);
      doStart(8'h05, 8'h05);
      waitDone(40, 1);

      // reset while in WAIT
      mem[3] = mkRow(48'h31, 48'h32, 48'h33, 48'h34);
      doStart(8'h03, 8'h04);
      chk("rst_fetch_addr", 64'({mem_rd, mem_addr}), 64'({1'b1, 8'h03}));
      tick();
      reset = 1'b1;
      tick();
      chkResetOuts("reset_in_wait");
      reset = 1'b0;
      expQ.delete();
      addrQ.delete();

      // start and abort together in IDLE: abort wins
      start_addr = 8'h00; end_addr = 8'h00; start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      chk("start_abort_idle", 64'({busy, mem_rd}), 64'(0));
      tick();
      chk("start_abort_stay", 64'({busy, mem_rd, out_valid}), 64'(0));

`ifdef ISCHED_ZERO_SKIP_EN
      // zero skip: row0 {0,5,0,7}, row1 empty
      mem[0] = mkRow(48'h0, 48'h5, 48'h0, 48'h7);
      mem[1] = '0;
      doStart(8'h00, 8'h01);
      waitDone(40, 3);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
